// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bundles the two requester ports and the ROM-side pins of
// rom_arbiter.
//   slave  modport : the arbiter's view (requests and ROM response in,
//                    completions, returned lines and ROM request out)
//   master modport : the requester/ROM environment's view (directions reversed)
// Signals:
//   req0_*  : port 0 (ICache refill) address/valid in, ready pulse/line out
//   req1_*  : port 1 (data-side line fetch) address/valid in, ready/line out
//   rom_*   : registered address/request out, ready pulse/line data in
//   busy_o  : arbiter is in a non-IDLE state
interface rom_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
);
    logic [ADDR_W-1:0] req0_addr_i;
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [DATA_W-1:0] req0_data_o;

    logic [ADDR_W-1:0] req1_addr_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [DATA_W-1:0] req1_data_o;

    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_valid_req_o;
    logic              rom_ready_i;
    logic [DATA_W-1:0] rom_data_i;

    logic              busy_o;

    modport slave (
        input  req0_addr_i, req0_valid_i, req1_addr_i, req1_valid_i,
        input  rom_ready_i, rom_data_i,
        output req0_ready_o, req0_data_o, req1_ready_o, req1_data_o,
        output rom_addr_o, rom_valid_req_o, busy_o
    );

    modport master (
        output req0_addr_i, req0_valid_i, req1_addr_i, req1_valid_i,
        output rom_ready_i, rom_data_i,
        input  req0_ready_o, req0_data_o, req1_ready_o, req1_data_o,
        input  rom_addr_o, rom_valid_req_o, busy_o
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single ROM port between port 0 (ICache refill) and
// port 1 (data-side line fetch). One transaction at a time: the winner's
// address is registered onto the ROM bus, and the ROM's ready pulse and line
// are routed back to the winner in the same cycle.
// Ports:
//   clk    : core clock
//   rst_n  : asynchronous active-low reset
//   bus    : rom_arbiter_if.slave (requester ports, ROM pins, busy_o)
// Build option:
//   ROM_ARB_ROUND_ROBIN_EN defined   -> a tie goes to the port that did not
//                                       win last (alternating grants)
//   ROM_ARB_ROUND_ROBIN_EN undefined -> a tie goes to port 1 (fixed priority)
module rom_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    rom_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS0 = 2'd1,
        ST_BUS1 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_valid;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic w_tie_pick1;
    logic w_grant1;
    logic w_any_valid;
    logic w_done0;
    logic w_done1;

    // Tie-break choice between the two ports
`ifdef ROM_ARB_ROUND_ROBIN_EN
    assign w_tie_pick1 = ~r_last_grant;
`else
    // Grant history is still tracked; fixed priority simply overrides it
    assign w_tie_pick1 = r_last_grant | 1'b1;
`endif

    assign w_any_valid = bus.req0_valid_i | bus.req1_valid_i;
    assign w_grant1    = bus.req1_valid_i & (~bus.req0_valid_i | w_tie_pick1);

    // ROM completion only counts while a transfer is actually on the bus
    assign w_done0 = (r_state == ST_BUS0) & bus.rom_ready_i;
    assign w_done1 = (r_state == ST_BUS1) & bus.rom_ready_i;

    // Completion is forwarded in the ROM's ready cycle; otherwise hold last line
    assign bus.req0_ready_o = w_done0;
    assign bus.req1_ready_o = w_done1;
    assign bus.req0_data_o  = w_done0 ? bus.rom_data_i : r_data0;
    assign bus.req1_data_o  = w_done1 ? bus.rom_data_i : r_data1;

    assign bus.rom_addr_o      = r_rom_addr;
    assign bus.rom_valid_req_o = r_rom_valid;
    assign bus.busy_o          = (r_state != ST_IDLE);

    // Arbitration FSM with registered ROM request and line capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_rom_addr   <= '0;
            r_rom_valid  <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_rom_valid <= 1'b1;
                        r_rom_addr  <= w_grant1 ? bus.req1_addr_i : bus.req0_addr_i;
                        r_state     <= w_grant1 ? ST_BUS1 : ST_BUS0;
                    end
                end
                ST_BUS0: begin
                    if (bus.rom_ready_i) begin
                        r_rom_valid  <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_data0      <= bus.rom_data_i;
                        r_state      <= ST_DONE;
                    end
                end
                ST_BUS1: begin
                    if (bus.rom_ready_i) begin
                        r_rom_valid  <= 1'b0;
                        r_last_grant <= 1'b1;
                        r_data1      <= bus.rom_data_i;
                        r_state      <= ST_DONE;
                    end
                end
                // One-cycle bubble so the winner can drop its valid
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter. Inputs are
// driven just after the falling edge and outputs observed 1 time unit later,
// so combinational ready/data and registered outputs are both stable.
module tb_rom_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 128;

    localparam logic [DATA_W-1:0] D_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    localparam logic [DATA_W-1:0] D_B = 128'h11111111_22222222_33333333_44444444;
    localparam logic [DATA_W-1:0] D_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [DATA_W-1:0] D_S = 128'h1234;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs;
        bus.req0_addr_i  = '0;
        bus.req0_valid_i = 1'b0;
        bus.req1_addr_i  = '0;
        bus.req1_valid_i = 1'b0;
        bus.rom_ready_i  = 1'b0;
        bus.rom_data_i   = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.rom_addr_o !== 32'h0) begin fails++; $display("FAIL reset_rom_addr: got %h want 0", bus.rom_addr_o); end
        checks++; if (bus.rom_valid_req_o !== 1'b0) begin fails++; $display("FAIL reset_rom_valid: got %b want 0", bus.rom_valid_req_o); end
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {bus.req0_ready_o, bus.req1_ready_o}); end
        checks++; if ((bus.req0_data_o | bus.req1_data_o) !== '0) begin fails++; $display("FAIL reset_data: got %h/%h want 0", bus.req0_data_o, bus.req1_data_o); end
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_port0;
        @(negedge clk);                         // cycle 0
        bus.req0_addr_i  = 32'h0000_0040;
        bus.req0_valid_i = 1'b1;
        #1;
        checks++; if (bus.rom_valid_req_o !== 1'b0) begin fails++; $display("FAIL single_c0_valid: got %b want 0", bus.rom_valid_req_o); end
        @(negedge clk); #1;                     // cycle 1
        checks++; if (bus.rom_valid_req_o !== 1'b1) begin fails++; $display("FAIL single_c1_valid: got %b want 1", bus.rom_valid_req_o); end
        checks++; if (bus.rom_addr_o !== 32'h40) begin fails++; $display("FAIL single_c1_addr: got %h want 40", bus.rom_addr_o); end
        checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL single_c1_busy: got %b want 1", bus.busy_o); end
        repeat (2) @(negedge clk);              // cycles 2,3
        #1;
        checks++; if (bus.req0_ready_o !== 1'b0) begin fails++; $display("FAIL single_c3_noready: got %b want 0", bus.req0_ready_o); end
        @(negedge clk);                         // cycle 4
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_A;
        #1;
        checks++; if (bus.req0_ready_o !== 1'b1) begin fails++; $display("FAIL single_c4_ready0: got %b want 1", bus.req0_ready_o); end
        checks++; if (bus.req0_data_o !== D_A) begin fails++; $display("FAIL single_c4_data0: got %h want %h", bus.req0_data_o, D_A); end
        checks++; if (bus.req1_ready_o !== 1'b0) begin fails++; $display("FAIL single_c4_ready1: got %b want 0", bus.req1_ready_o); end
        checks++; if (bus.rom_addr_o !== 32'h40) begin fails++; $display("FAIL single_c4_addr_held: got %h want 40", bus.rom_addr_o); end
        @(negedge clk);                         // cycle 5 (DONE)
        bus.rom_ready_i  = 1'b0;
        bus.rom_data_i   = '0;
        bus.req0_valid_i = 1'b0;
        #1;
        checks++; if (bus.rom_valid_req_o !== 1'b0) begin fails++; $display("FAIL single_c5_valid: got %b want 0", bus.rom_valid_req_o); end
        checks++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL single_c5_busy: got %b want 1", bus.busy_o); end
        @(negedge clk); #1;                     // cycle 6 (IDLE)
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL single_c6_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.req0_data_o !== D_A) begin fails++; $display("FAIL single_c6_data_kept: got %h want %h", bus.req0_data_o, D_A); end
    endtask

    task automatic test_simultaneous;
        @(negedge clk);                         // cycle 0
        bus.req0_addr_i  = 32'h100;
        bus.req0_valid_i = 1'b1;
        bus.req1_addr_i  = 32'h200;
        bus.req1_valid_i = 1'b1;
        @(negedge clk); #1;                     // cycle 1: port 1 wins (last grant was 0)
        checks++; if (bus.rom_addr_o !== 32'h200) begin fails++; $display("FAIL simul_first_addr: got %h want 200", bus.rom_addr_o); end
        @(negedge clk);                         // cycle 2
        @(negedge clk);                         // cycle 3: ROM completes
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_B;
        #1;
        checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b10) begin fails++; $display("FAIL simul_ready1: got %b want 10", {bus.req1_ready_o, bus.req0_ready_o}); end
        checks++; if (bus.req1_data_o !== D_B) begin fails++; $display("FAIL simul_data1: got %h want %h", bus.req1_data_o, D_B); end
        @(negedge clk);                         // cycle 4 (DONE)
        bus.rom_ready_i  = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(negedge clk); #1;                     // cycle 5 (IDLE, grants port 0)
        checks++; if (bus.rom_valid_req_o !== 1'b0) begin fails++; $display("FAIL simul_idle_valid: got %b want 0", bus.rom_valid_req_o); end
        @(negedge clk); #1;                     // cycle 6
        checks++; if (bus.rom_addr_o !== 32'h100 || bus.rom_valid_req_o !== 1'b1) begin fails++; $display("FAIL simul_second_issue: got %h/%b want 100/1", bus.rom_addr_o, bus.rom_valid_req_o); end
        @(negedge clk);                         // cycle 7
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_C;
        #1;
        checks++; if (bus.req0_ready_o !== 1'b1 || bus.req0_data_o !== D_C) begin fails++; $display("FAIL simul_ready0: got %b/%h want 1/%h", bus.req0_ready_o, bus.req0_data_o, D_C); end
        @(negedge clk);
        bus.rom_ready_i  = 1'b0;
        bus.rom_data_i   = '0;
        bus.req0_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_ready;
        @(negedge clk);
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_S;
        #1;
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b00) begin fails++; $display("FAIL stray_ready: got %b want 00", {bus.req0_ready_o, bus.req1_ready_o}); end
        checks++; if (bus.req0_data_o !== D_C || bus.req1_data_o !== D_B) begin fails++; $display("FAIL stray_data_live: got %h/%h want %h/%h", bus.req0_data_o, bus.req1_data_o, D_C, D_B); end
        @(negedge clk);
        bus.rom_ready_i = 1'b0;
        bus.rom_data_i  = '0;
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL stray_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.req0_data_o !== D_C || bus.req1_data_o !== D_B) begin fails++; $display("FAIL stray_data_kept: got %h/%h want %h/%h", bus.req0_data_o, bus.req1_data_o, D_C, D_B); end
    endtask

    task automatic test_late_arrival;
        @(negedge clk);                         // cycle 0
        bus.req0_addr_i  = 32'h0000_0A00;
        bus.req0_valid_i = 1'b1;
        @(negedge clk);                         // cycle 1 (BUS0)
        @(negedge clk);                         // cycle 2: port 1 arrives late
        bus.req1_addr_i  = 32'h300;
        bus.req1_valid_i = 1'b1;
        @(negedge clk); #1;                     // cycle 3
        checks++; if (bus.rom_addr_o !== 32'hA00 || bus.rom_valid_req_o !== 1'b1) begin fails++; $display("FAIL late_addr_held: got %h/%b want a00/1", bus.rom_addr_o, bus.rom_valid_req_o); end
        @(negedge clk);                         // cycle 4: port 0 completes
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_A;
        #1;
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o} !== 2'b10) begin fails++; $display("FAIL late_ready0: got %b want 10", {bus.req0_ready_o, bus.req1_ready_o}); end
        @(negedge clk);                         // cycle 5 (DONE)
        bus.rom_ready_i  = 1'b0;
        bus.req0_valid_i = 1'b0;
        @(negedge clk); #1;                     // cycle 6 (IDLE, grants port 1)
        checks++; if (bus.rom_valid_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin fails++; $display("FAIL late_idle: got %b/%b want 0/0", bus.rom_valid_req_o, bus.busy_o); end
        @(negedge clk); #1;                     // cycle 7
        checks++; if (bus.rom_addr_o !== 32'h300 || bus.rom_valid_req_o !== 1'b1) begin fails++; $display("FAIL late_issue1: got %h/%b want 300/1", bus.rom_addr_o, bus.rom_valid_req_o); end
        @(negedge clk);
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_B;
        #1;
        checks++; if (bus.req1_ready_o !== 1'b1 || bus.req1_data_o !== D_B) begin fails++; $display("FAIL late_ready1: got %b/%h want 1/%h", bus.req1_ready_o, bus.req1_data_o, D_B); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus;
        @(negedge clk);
        bus.req0_addr_i  = 32'h80;
        bus.req0_valid_i = 1'b1;
        @(negedge clk); #1;                     // BUS0
        checks++; if (bus.rom_valid_req_o !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid: got %b want 1", bus.rom_valid_req_o); end
        #2;
        rst_n = 1'b0;                           // asynchronous, away from any edge
        bus.rom_ready_i = 1'b1;
        bus.rom_data_i  = D_C;
        #1;
        checks++; if (bus.rom_valid_req_o !== 1'b0 || bus.rom_addr_o !== 32'h0) begin fails++; $display("FAIL midrst_rom: got %b/%h want 0/0", bus.rom_valid_req_o, bus.rom_addr_o); end
        checks++; if ({bus.req0_ready_o, bus.req1_ready_o, bus.busy_o} !== 3'b000) begin fails++; $display("FAIL midrst_flags: got %b want 000", {bus.req0_ready_o, bus.req1_ready_o, bus.busy_o}); end
        checks++; if ((bus.req0_data_o | bus.req1_data_o) !== '0) begin fails++; $display("FAIL midrst_data: got %h/%h want 0", bus.req0_data_o, bus.req1_data_o); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.rom_valid_req_o !== 1'b0) begin fails++; $display("FAIL midrst_after: got %b/%b want 0/0", bus.busy_o, bus.rom_valid_req_o); end
    endtask

    // Both ports keep requesting; each winner drops valid for the DONE and
    // IDLE cycles, then re-requests. Grant order depends on the tie-break.
    task automatic test_contention;
        int grants[$];
        int exp_order[4];
        int rom_wait;
        int dn0;
        int dn1;
        bit seen0;
        bit seen1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{1, 0, 1, 0};
`endif
        rom_wait = 0; dn0 = 0; dn1 = 0; seen0 = 1'b0; seen1 = 1'b0;
        @(negedge clk);
        bus.req0_addr_i  = 32'h400;
        bus.req1_addr_i  = 32'h500;
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        for (int cyc = 0; cyc < 200 && grants.size() < 4; cyc++) begin
            @(negedge clk);
            if (seen0) begin bus.req0_valid_i = 1'b0; dn0 = 2; seen0 = 1'b0; end
            else if (dn0 > 0) begin dn0--; if (dn0 == 0) bus.req0_valid_i = 1'b1; end
            if (seen1) begin bus.req1_valid_i = 1'b0; dn1 = 2; seen1 = 1'b0; end
            else if (dn1 > 0) begin dn1--; if (dn1 == 0) bus.req1_valid_i = 1'b1; end
            if (bus.rom_ready_i) begin
                bus.rom_ready_i = 1'b0;
                rom_wait = 0;
            end else if (bus.rom_valid_req_o) begin
                rom_wait++;
                if (rom_wait == 2) begin
                    bus.rom_ready_i = 1'b1;
                    bus.rom_data_i  = {4{bus.rom_addr_o}};
                end
            end
            #1;
            if (bus.req0_ready_o) begin grants.push_back(0); seen0 = 1'b1; end
            if (bus.req1_ready_o) begin grants.push_back(1); seen1 = 1'b1; end
        end
        checks++;
        if (grants.size() != 4) begin
            fails++;
            $display("FAIL contention_count: got %0d grants want 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[i] != exp_order[i]) begin fails++; $display("FAIL contention_grant%0d: got port %0d want port %0d", i, grants[i], exp_order[i]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_single_port0();
        test_simultaneous();
        test_stray_ready();
        test_late_arrival();
        test_reset_mid_bus();
        test_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
